hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/hazard_ctrl_if.sv | 34 +++
 rtl/busy_watchdog.sv | 30 +++
 rtl/hazard_ctrl.sv | 117 +++++++++++
 tb/tb_hazard_ctrl.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared hazard controller types, constants and load-use helper
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LU_HOLD    = 2'd1,
        WAIT       = 2'd2,
        FLUSH_PEND = 2'd3
    } hz_state_t;

    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam logic [7:0] BUSY_LIMIT = 8'd255;

    // A load in EX whose destination feeds the ID instruction; $zero never hazards.
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] rt_ex,
        input logic [4:0] rs_id,
        input logic [4:0] rt_id,
        input logic       uses_rt
    );
        return mem_read && (rt_ex != REG_ZERO) &&
               ((rt_ex == rs_id) || (uses_rt && (rt_ex == rt_id)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - hazard controller signal bundle with driver/controller views
interface hazard_ctrl_if;
    logic        MemRead_in_EX;
    logic [4:0]  rt_EX;
    logic [4:0]  rs_ID;
    logic [4:0]  rt_ID;
    logic        uses_rt_ID;
    logic        jump_in_EX;
    logic        Branch_taken_MEM;
    logic        mem_busy;
    logic        PC_write;
    logic        IF_ID_write;
    logic        IF_ID_flush;
    logic        ID_EX_bubble;
    logic        EX_MEM_flush;
    logic        pipe_freeze;
    logic        timeout;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    modport master (
        output MemRead_in_EX, rt_EX, rs_ID, rt_ID, uses_rt_ID,
               jump_in_EX, Branch_taken_MEM, mem_busy,
        input  PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble,
               EX_MEM_flush, pipe_freeze, timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  MemRead_in_EX, rt_EX, rs_ID, rt_ID, uses_rt_ID,
               jump_in_EX, Branch_taken_MEM, mem_busy,
        output PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble,
               EX_MEM_flush, pipe_freeze, timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/busy_watchdog.sv
// rtl/busy_watchdog.sv - consecutive mem_busy cycle counter with sticky timeout
module busy_watchdog
    import pipe_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic mem_busy,
    output logic timeout
);

    logic [7:0] busy_cnt;

    // Count busy cycles (saturating); the cycle that reaches the limit latches timeout.
    always_ff @(posedge clock) begin
        if (!reset) begin
            busy_cnt <= '0;
            timeout  <= 1'b0;
        end else if (mem_busy) begin
            if (busy_cnt != BUSY_LIMIT) begin
                busy_cnt <= busy_cnt + 8'd1;
            end
            if (busy_cnt >= BUSY_LIMIT - 8'd1) begin
                timeout <= 1'b1;
            end
        end else begin
            busy_cnt <= '0;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller; HAZARD_STATS_EN enables stall/flush counters
module hazard_ctrl
    import pipe_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    hazard_ctrl_if.slave  hz
);

    hz_state_t state, state_nxt;
    logic      pend_br, pend_jmp, pend_br_nxt, pend_jmp_nxt;
    logic      do_br, do_jmp;
    logic      timeout_q;
    logic      pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, pipe_freeze;

    // A flush latched during a busy stretch is replayed on the first non-busy cycle.
    assign do_br  = hz.Branch_taken_MEM || ((state == FLUSH_PEND) && pend_br);
    assign do_jmp = hz.jump_in_EX       || ((state == FLUSH_PEND) && pend_jmp);

    // State and pending-flush latch registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= RUN;
            pend_br  <= 1'b0;
            pend_jmp <= 1'b0;
        end else begin
            state    <= state_nxt;
            pend_br  <= pend_br_nxt;
            pend_jmp <= pend_jmp_nxt;
        end
    end

    // Next-state and control decode: busy > branch > jump > load-use.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_flush = 1'b0;
        pipe_freeze  = 1'b0;
        state_nxt    = RUN;
        pend_br_nxt  = pend_br;
        pend_jmp_nxt = pend_jmp;
        if (!reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            pend_br_nxt  = 1'b0;
            pend_jmp_nxt = 1'b0;
        end else if (hz.mem_busy) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            pipe_freeze  = 1'b1;
            pend_br_nxt  = pend_br  || hz.Branch_taken_MEM;
            pend_jmp_nxt = pend_jmp || hz.jump_in_EX;
            state_nxt    = (pend_br_nxt || pend_jmp_nxt) ? FLUSH_PEND : WAIT;
        end else begin
            pend_br_nxt  = 1'b0;
            pend_jmp_nxt = 1'b0;
            if (do_br) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (do_jmp) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if ((state != LU_HOLD) &&
                         load_use_hit(hz.MemRead_in_EX, hz.rt_EX, hz.rs_ID,
                                      hz.rt_ID, hz.uses_rt_ID)) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                state_nxt    = LU_HOLD;
            end
        end
    end

    busy_watchdog u_busy_watchdog (
        .clock    (clock),
        .reset    (reset),
        .mem_busy (hz.mem_busy),
        .timeout  (timeout_q)
    );

    assign hz.PC_write     = pc_write;
    assign hz.IF_ID_write  = if_id_write;
    assign hz.IF_ID_flush  = if_id_flush;
    assign hz.ID_EX_bubble = id_ex_bubble;
    assign hz.EX_MEM_flush = ex_mem_flush;
    assign hz.pipe_freeze  = pipe_freeze;
    assign hz.timeout      = reset && timeout_q;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_q, flush_q;

    // Saturating event counters for stalled fetch cycles and IF/ID flushes.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_write && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
            if (if_id_flush && (flush_q != 16'hFFFF)) begin
                flush_q <= flush_q + 16'd1;
            end
        end
    end

    assign hz.stall_cnt = stall_q;
    assign hz.flush_cnt = flush_q;
`else
    assign hz.stall_cnt = '0;
    assign hz.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

    // Output vector order: PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_MEM_flush, pipe_freeze, timeout
    localparam logic [6:0] O_RST   = 7'b0000000;
    localparam logic [6:0] O_RUN   = 7'b1100000;
    localparam logic [6:0] O_STALL = 7'b0001000;
    localparam logic [6:0] O_BR    = 7'b1111100;
    localparam logic [6:0] O_JMP   = 7'b1111000;
    localparam logic [6:0] O_FRZ   = 7'b0000010;
    localparam logic [6:0] O_TO    = 7'b1100001;

    typedef struct packed {
        logic       rst;
        logic       mr;
        logic [4:0] rte;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ur;
        logic       jmp;
        logic       br;
        logic       busy;
        logic [6:0] e;
    } vec_t;

    logic clock;
    logic reset;
    hazard_ctrl_if hz ();

    hazard_ctrl dut (
        .clock (clock),
        .reset (reset),
        .hz    (hz.slave)
    );

    logic [6:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(logic rst, logic mr, logic [4:0] rte, logic [4:0] rs,
                                logic [4:0] rt, logic ur, logic jmp, logic br,
                                logic busy, logic [6:0] e);
        vec_t v;
        v = '{rst, mr, rte, rs, rt, ur, jmp, br, busy, e};
        return v;
    endfunction

    function automatic vec_t idle(logic [6:0] e);
        return mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, e);
    endfunction

    function automatic vec_t rst_v();
        return mk(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_RST);
    endfunction

    function automatic logic [6:0] outs();
        return {hz.PC_write, hz.IF_ID_write, hz.IF_ID_flush, hz.ID_EX_bubble,
                hz.EX_MEM_flush, hz.pipe_freeze, hz.timeout};
    endfunction

    task automatic step(input vec_t v);
        @(negedge clock);
        reset               = v.rst;
        hz.MemRead_in_EX    = v.mr;
        hz.rt_EX            = v.rte;
        hz.rs_ID            = v.rs;
        hz.rt_ID            = v.rt;
        hz.uses_rt_ID       = v.ur;
        hz.jump_in_EX       = v.jmp;
        hz.Branch_taken_MEM = v.br;
        hz.mem_busy         = v.busy;
        exp_q.push_back(v.e);
        #1;
    endtask

    task automatic test_reset();
        vec_t tbl[$];
        logic [6:0] e;
        tbl.push_back(rst_v());
        tbl.push_back(mk(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, O_RST));
        tbl.push_back(rst_v());
        foreach (tbl[i]) begin
            step(tbl[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if (outs() !== e) begin
                $display("FAIL reset[%0d]: got %b want %b", i, outs(), e);
                n_bad++;
            end
        end
        n_cmp++;
        if ({hz.stall_cnt, hz.flush_cnt} !== 32'd0) begin
            $display("FAIL reset_counters: got %0d/%0d want 0/0", hz.stall_cnt, hz.flush_cnt);
            n_bad++;
        end
    endtask

    task automatic test_stats();
        vec_t tbl[$];
        logic [6:0] e;
        logic [15:0] want_stall, want_flush;
`ifdef HAZARD_STATS_EN
        want_stall = 16'd2;
        want_flush = 16'd1;
`else
        want_stall = 16'd0;
        want_flush = 16'd0;
`endif
        tbl.push_back(mk(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_STALL));
        tbl.push_back(idle(O_RUN));
        tbl.push_back(mk(1'b1, 1'b1, 5'd4, 5'd1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, O_STALL));
        tbl.push_back(idle(O_RUN));
        tbl.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_JMP));
        tbl.push_back(idle(O_RUN));
        foreach (tbl[i]) begin
            step(tbl[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if (outs() !== e) begin
                $display("FAIL stats_seq[%0d]: got %b want %b", i, outs(), e);
                n_bad++;
            end
        end
        n_cmp++;
        if (hz.stall_cnt !== want_stall) begin
            $display("FAIL stall_cnt: got %0d want %0d", hz.stall_cnt, want_stall);
            n_bad++;
        end
        n_cmp++;
        if (hz.flush_cnt !== want_flush) begin
            $display("FAIL flush_cnt: got %0d want %0d", hz.flush_cnt, want_flush);
            n_bad++;
        end
    endtask

    task automatic test_load_use();
        vec_t tbl[$];
        logic [6:0] e;
        tbl.push_back(idle(O_RUN));
        tbl.push_back(mk(1'b1, 1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, O_STALL));
        tbl.push_back(mk(1'b1, 1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN));
        tbl.push_back(idle(O_RUN));
        tbl.push_back(mk(1'b1, 1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_STALL));
        tbl.push_back(mk(1'b1, 1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_RUN));
        tbl.push_back(mk(1'b1, 1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_RUN));
        foreach (tbl[i]) begin
            step(tbl[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if (outs() !== e) begin
                $display("FAIL load_use[%0d]: got %b want %b", i, outs(), e);
                n_bad++;
            end
        end
    endtask

    task automatic test_no_stall();
        vec_t tbl[$];
        logic [6:0] e;
        tbl.push_back(mk(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_RUN));
        tbl.push_back(mk(1'b1, 1'b1, 5'd9, 5'd1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN));
        tbl.push_back(mk(1'b1, 1'b1, 5'd9, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, O_RUN));
        foreach (tbl[i]) begin
            step(tbl[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if (outs() !== e) begin
                $display("FAIL no_stall[%0d]: got %b want %b", i, outs(), e);
                n_bad++;
            end
        end
    endtask

    task automatic test_priority();
        vec_t tbl[$];
        logic [6:0] e;
        tbl.push_back(mk(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_BR));
        tbl.push_back(idle(O_RUN));
        tbl.push_back(mk(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_JMP));
        tbl.push_back(idle(O_RUN));
        tbl.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, O_BR));
        tbl.push_back(idle(O_RUN));
        foreach (tbl[i]) begin
            step(tbl[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if (outs() !== e) begin
                $display("FAIL priority[%0d]: got %b want %b", i, outs(), e);
                n_bad++;
            end
        end
    endtask

    task automatic test_busy_flush();
        vec_t tbl[$];
        logic [6:0] e;
        // branch pulsed in first of three busy cycles
        tbl.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, O_FRZ));
        tbl.push_back(mk(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_FRZ));
        tbl.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_FRZ));
        tbl.push_back(mk(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_BR));
        tbl.push_back(idle(O_RUN));
        // latched jump
        tbl.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, O_FRZ));
        tbl.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_FRZ));
        tbl.push_back(idle(O_JMP));
        tbl.push_back(idle(O_RUN));
        // jump then branch while busy: branch kind wins
        tbl.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, O_FRZ));
        tbl.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, O_FRZ));
        tbl.push_back(idle(O_BR));
        tbl.push_back(idle(O_RUN));
        // plain busy returns straight to RUN and evaluates load-use
        tbl.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_FRZ));
        tbl.push_back(mk(1'b1, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_STALL));
        tbl.push_back(idle(O_RUN));
        foreach (tbl[i]) begin
            step(tbl[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if (outs() !== e) begin
                $display("FAIL busy_flush[%0d]: got %b want %b", i, outs(), e);
                n_bad++;
            end
        end
    endtask

    task automatic test_reset_mid();
        vec_t tbl[$];
        logic [6:0] e;
        tbl.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, O_FRZ));
        tbl.push_back(rst_v());
        tbl.push_back(idle(O_RUN));
        tbl.push_back(mk(1'b1, 1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_STALL));
        tbl.push_back(rst_v());
        tbl.push_back(idle(O_RUN));
        foreach (tbl[i]) begin
            step(tbl[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if (outs() !== e) begin
                $display("FAIL reset_mid[%0d]: got %b want %b", i, outs(), e);
                n_bad++;
            end
        end
    endtask

    task automatic test_timeout();
        vec_t tbl[$];
        logic [6:0] e;
        tbl.push_back(rst_v());
        for (int k = 0; k < 255; k++) begin
            tbl.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_FRZ));
        end
        tbl.push_back(idle(O_TO));
        tbl.push_back(idle(O_TO));
        tbl.push_back(rst_v());
        tbl.push_back(idle(O_RUN));
        foreach (tbl[i]) begin
            step(tbl[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if (outs() !== e) begin
                $display("FAIL timeout[%0d]: got %b want %b", i, outs(), e);
                n_bad++;
            end
        end
    endtask

    initial begin
        reset               = 1'b0;
        hz.MemRead_in_EX    = 1'b0;
        hz.rt_EX            = 5'd0;
        hz.rs_ID            = 5'd0;
        hz.rt_ID            = 5'd0;
        hz.uses_rt_ID       = 1'b0;
        hz.jump_in_EX       = 1'b0;
        hz.Branch_taken_MEM = 1'b0;
        hz.mem_busy         = 1'b0;
        test_reset();
        test_stats();
        test_load_use();
        test_no_stall();
        test_priority();
        test_busy_flush();
        test_reset_mid();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
